// File: rtl/dct_xpose_pingpong_ctrl.sv
// Ping-pong sequencer for two 8x8 DCT transpose banks: steers writes into the filling bank and
// drains the other as a gap-free 64-word stream. Optional DCT_XPOSE_FASTSYNC_EN adds bank_rst.
module dct_xpose_pingpong_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BLK_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              en_write0,
  output logic              en_write1,
  input  logic [DATA_W-1:0] mem0_q,
  input  logic [DATA_W-1:0] mem1_q,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last
`ifdef DCT_XPOSE_FASTSYNC_EN
  ,
  output logic [1:0]        bank_rst
`endif
);

  localparam int unsigned CntW = $clog2(BLK_WORDS);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(BLK_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StFull, StDrain} bank_st_e;

  bank_st_e        st_q   [2];
  bank_st_e        st_d   [2];
  logic [CntW-1:0] wcnt_q [2];
  logic [CntW-1:0] wcnt_d [2];
  logic [CntW-1:0] rph_q  [2];
  logic [CntW-1:0] rph_d  [2];
  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic            out_valid_q, out_valid_d;
  logic            out_first_q, out_first_d;
  logic            out_last_q, out_last_d;
  logic            rd_bank_q, rd_bank_d;
  logic [1:0]      wr_en;
  logic [1:0]      hold;

`ifdef DCT_XPOSE_FASTSYNC_EN
  logic [1:0] brst_q, brst_d;
  // A bank held in reset neither advances its read pointer nor can be drained.
  assign hold     = brst_q;
  assign bank_rst = brst_q;
`else
  assign hold = 2'b00;
`endif

  always_comb begin
    in_ready = (st_q[wr_sel_q] == StIdle) || (st_q[wr_sel_q] == StFill);
    wr_en[0] = in_valid & in_ready & ~wr_sel_q;
    wr_en[1] = in_valid & in_ready & wr_sel_q;
  end

  assign en_write0 = wr_en[0];
  assign en_write1 = wr_en[1];

  always_comb begin
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    rd_bank_d   = rd_bank_q;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
`ifdef DCT_XPOSE_FASTSYNC_EN
    brst_d      = 2'b00;
`endif
    for (int b = 0; b < 2; b++) begin
      st_d[b]   = st_q[b];
      wcnt_d[b] = wr_en[b] ? wcnt_q[b] + CntOne : wcnt_q[b];
      // Shadow of the bank's free-running read pointer: moves on every non-write edge.
      rph_d[b]  = (wr_en[b] || hold[b]) ? rph_q[b] : rph_q[b] + CntOne;
      unique case (st_q[b])
        StIdle: begin
          if (wr_en[b]) st_d[b] = StFill;
        end
        StFill: begin
          if (wr_en[b] && wcnt_q[b] == CntLast) begin
            st_d[b]  = StFull;
            wr_sel_d = ~wr_sel_q;
`ifdef DCT_XPOSE_FASTSYNC_EN
            if (rph_q[b] != '0) begin
              brst_d[b] = 1'b1;
              rph_d[b]  = '0;
              wcnt_d[b] = '0;
            end
`endif
          end
        end
        StFull: begin
          if (rd_sel_q == 1'(b) && st_q[1-b] != StDrain && rph_q[b] == '0 && !hold[b]) begin
            st_d[b]     = StDrain;
            out_valid_d = 1'b1;
            out_first_d = 1'b1;
            rd_bank_d   = 1'(b);
          end
        end
        StDrain: begin
          out_valid_d = 1'b1;
          if (rph_q[b] == CntLast) begin
            out_last_d = 1'b1;
            st_d[b]    = StIdle;
            rd_sel_d   = ~rd_sel_q;
          end
        end
        default: st_d[b] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]   <= StIdle;
        wcnt_q[b] <= '0;
        rph_q[b]  <= '0;
      end
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef DCT_XPOSE_FASTSYNC_EN
      brst_q      <= 2'b00;
`endif
    end else begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]   <= st_d[b];
        wcnt_q[b] <= wcnt_d[b];
        rph_q[b]  <= rph_d[b];
      end
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
`ifdef DCT_XPOSE_FASTSYNC_EN
      brst_q      <= brst_d;
`endif
    end
  end

  // Bank output registers hold word k after edge k, so the data path is a plain mux.
  assign dout      = out_valid_q ? (rd_bank_q ? mem1_q : mem0_q) : '0;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct_xpose_pingpong_ctrl.sv
// Bench for dct_xpose_pingpong_ctrl with behavioural transpose banks and a scoreboard monitor.
// Defining DCT_XPOSE_FASTSYNC_EN also exercises bank_rst.
module tb_dct_xpose_pingpong_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] wdata = '0;
  logic        in_ready, en_write0, en_write1;
  logic [31:0] mem0_q, mem1_q, dout;
  logic        out_valid, out_first, out_last;
  logic [1:0]  brst;

  int errors = 0;
  int checks = 0;
  int stall_cyc = 0;
  int bad_wr = 0;

  typedef struct packed {
    logic        f;
    logic        l;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

`ifdef DCT_XPOSE_FASTSYNC_EN
  logic [1:0] bank_rst;
  assign brst = bank_rst;
`else
  assign brst = 2'b00;
`endif

  dct_xpose_pingpong_ctrl #(.DATA_W(32), .BLK_WORDS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .en_write0 (en_write0),
    .en_write1 (en_write1),
    .mem0_q    (mem0_q),
    .mem1_q    (mem1_q),
    .dout      (dout),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last)
`ifdef DCT_XPOSE_FASTSYNC_EN
    ,
    .bank_rst  (bank_rst)
`endif
  );

  // Transpose banks: column-major write, row-major read, read pointer moves when not writing.
  logic [31:0] bq [2];
  for (genvar g = 0; g < 2; g++) begin : g_bank
    logic [31:0] m [64];
    logic [5:0]  wp, rp;
    logic [31:0] q;
    wire         brst_w = rst | brst[g];
    wire         we = (g == 0) ? en_write0 : en_write1;
    always @(posedge clk or posedge brst_w) begin
      if (brst_w) begin
        wp <= '0;
        rp <= '0;
        q  <= '0;
      end else if (we) begin
        m[{wp[2:0], wp[5:3]}] <= wdata;
        wp <= wp + 6'd1;
      end else begin
        q  <= m[rp];
        rp <= rp + 6'd1;
      end
    end
    assign bq[g] = q;
  end
  assign mem0_q = bq[0];
  assign mem1_q = bq[1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && !in_ready) stall_cyc++;
      if ((en_write0 || en_write1) && !in_ready) bad_wr++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got dout 0x%0h required no output", dout);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_word", {30'd0, out_first, out_last, dout}, {30'd0, e.f, e.l, e.d});
        end
      end else if (out_first || out_last) begin
        chk("flag_without_valid", {62'd0, out_first, out_last}, 64'd0);
      end
    end
  end

  task automatic push_block(input int base);
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      e.d = 32'(base + (k % 8) * 8 + k / 8);
      e.f = (k == 0);
      e.l = (k == 63);
      exp_q.push_back(e);
    end
  endtask

  // Enter and leave at a negedge; the word is accepted at the posedge in between.
  task automatic put_word(input int v);
    int t = 0;
    in_valid = 1'b1;
    wdata    = 32'(v);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      $display("FAIL put_word_timeout: got in_ready 0 required 1");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic put_block(input int base);
    push_block(base);
    for (int w = 0; w < 64; w++) put_word(base + w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_first(output int n);
    n = 0;
    while (!out_first && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int hi;

  initial begin
    // Reset state
    do_reset();
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_flags", {59'd0, out_valid, out_first, out_last, en_write0, en_write1}, 64'd0);
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_bank_rst", 64'(brst), 64'd0);

    // Single block 0..63, output is the transpose
    put_block(0);
    wait_drain("blk1_drained");

    // Four back-to-back blocks: no stall and an unbroken 256-word output stream
    do_reset();
    stall_cyc = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) put_block(1000 + i * 64);
        in_valid = 1'b0;
      end
      begin
        int t = 0;
        while (!out_valid && t < 300) begin
          @(negedge clk);
          t++;
        end
        hi = 0;
        for (int i = 0; i < 256; i++) begin
          if (out_valid) hi++;
          @(negedge clk);
        end
      end
    join
    chk("cont_no_stall", 64'(stall_cyc), 64'd0);
    chk("cont_out_gapless", 64'(hi), 64'd256);
    wait_drain("cont_drained");

    // Idle cycle after every 5th word: fill ends with rph=12
    do_reset();
    push_block(2000);
    for (int w = 0; w < 64; w++) begin
      put_word(2000 + w);
      if (w % 5 == 4 && w != 63) idle_cycle();
    end
    in_valid = 1'b0;
    wait_first(n);
`ifdef DCT_XPOSE_FASTSYNC_EN
    chk("gap_first_delay", 64'(n), 64'd2);
`else
    chk("gap_first_delay", 64'(n), 64'd53);
`endif
    wait_drain("gap_drained");

    // Gapped block then two streaming blocks: second bank fills while first still drains
    do_reset();
    stall_cyc = 0;
    push_block(3000);
    for (int w = 0; w < 64; w++) begin
      put_word(3000 + w);
      if (w % 5 == 4 && w != 63) idle_cycle();
    end
    put_block(3064);
    put_block(3128);
    in_valid = 1'b0;
`ifdef DCT_XPOSE_FASTSYNC_EN
    chk("stall_cycles", 64'(stall_cyc), 64'd1);
`else
    chk("stall_cycles", 64'(stall_cyc), 64'd52);
`endif
    wait_drain("stall_drained");
    chk("no_write_while_stalled", 64'(bad_wr), 64'd0);

    // Reset after 30 writes into bank1 while bank0 drains
    do_reset();
    put_block(4000);
    for (int w = 0; w < 30; w++) put_word(5000 + w);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_flags", {59'd0, out_valid, out_first, out_last, en_write0, en_write1}, 64'd0);
    chk("midrst_dout", 64'(dout), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    put_block(6000);
    wait_drain("midrst_drained");

    // Fill completes with rph=17
    do_reset();
    push_block(7000);
    for (int w = 0; w < 10; w++) put_word(7000 + w);
    for (int i = 0; i < 17; i++) idle_cycle();
    for (int w = 10; w < 64; w++) put_word(7000 + w);
    in_valid = 1'b0;
`ifdef DCT_XPOSE_FASTSYNC_EN
    chk("fastsync_pulse", 64'(brst), 64'd1);
    @(negedge clk);
    chk("fastsync_pulse_end", 64'(brst), 64'd0);
    wait_first(n);
    chk("fastsync_first_delay", 64'(n + 1), 64'd2);
`else
    wait_first(n);
    chk("rph17_first_delay", 64'(n), 64'd48);
`endif
    wait_drain("rph17_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
